// File: rtl/iob_cache_axi_write_responder.sv
// AXI4 write-slave front end for a cache backing memory: one burst at a time,
// every accepted W beat becomes a single-cycle full-width memory write.
// Ports: clk_i/reset_i, AXI AW/W/B slave channels, mem_en/addr/wdata/wstrb master.
// Latency: a beat's memory write is combinational, in the same cycle as its W handshake.
// Backpressure: AW accepted only in IDLE and W only in DATA; B is held until bready.
// Optional macro IOB_CACHE_AXI_RANGE_CHECK_EN: suppress writes whose word address
// exceeds the memory range and report them as SLVERR.
module iob_cache_axi_write_responder #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [AXI_ID_W-1:0]     axi_awid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic [2:0]              axi_awsize_i,
  input  logic [1:0]              axi_awburst_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  output logic [AXI_ID_W-1:0]     axi_bid_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  output logic                    mem_en_o,
  output logic [MEM_ADDR_W-1:0]   mem_addr_o,
  output logic [AXI_DATA_W-1:0]   mem_wdata_o,
  output logic [AXI_DATA_W/8-1:0] mem_wstrb_o
);

  localparam int STRB_W  = AXI_DATA_W / 8;
  localparam int OFF_W   = $clog2(STRB_W);
  localparam int WADDR_W = AXI_ADDR_W - OFF_W;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                 state, state_nxt;
  logic [AXI_ID_W-1:0]    id_q;
  logic [WADDR_W-1:0]     waddr_q;   // word address, byte offset dropped
  logic [AXI_LEN_W-1:0]   len_q;
  logic [1:0]             burst_q;
  logic [AXI_LEN_W-1:0]   cnt_q;
  logic                   err_q;

  logic beat;
  logic last_beat;
  logic out_of_range;

  assign beat      = (state == DATA) && axi_wvalid_i;
  assign last_beat = (cnt_q == len_q);

`ifdef IOB_CACHE_AXI_RANGE_CHECK_EN
  assign out_of_range = (waddr_q >> MEM_ADDR_W) != '0;
`else
  assign out_of_range = 1'b0;
`endif

  // awsize is ignored (beats are always full width); the byte offset of awaddr
  // is dropped, and without range checking the upper word bits simply alias.
  logic unused_bits;
  assign unused_bits = ^{axi_awsize_i, axi_awaddr_i, waddr_q};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      id_q    <= '0;
      waddr_q <= '0;
      len_q   <= '0;
      burst_q <= 2'b00;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && axi_awvalid_i) begin
        id_q    <= axi_awid_i;
        waddr_q <= axi_awaddr_i[AXI_ADDR_W-1:OFF_W];
        len_q   <= axi_awlen_i;
        burst_q <= axi_awburst_i;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end
      if (beat) begin
        cnt_q <= cnt_q + 1'b1;
        // Only the memory field increments so bursts wrap inside the memory
        // and never spill into the range-checked upper bits.
        if (burst_q != 2'b00)
          waddr_q[MEM_ADDR_W-1:0] <= waddr_q[MEM_ADDR_W-1:0] + 1'b1;
        // Reserved burst types run as INCR but are reported; wlast is only
        // a consistency check, the burst length always comes from awlen.
        if ((axi_wlast_i != last_beat) || burst_q[1] || out_of_range)
          err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    axi_awready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    mem_en_o      = 1'b0;
    case (state)
      IDLE: begin
        axi_awready_o = 1'b1;
        if (axi_awvalid_i) state_nxt = DATA;
      end
      DATA: begin
        axi_wready_o = 1'b1;
        mem_en_o     = axi_wvalid_i && !out_of_range;
        if (axi_wvalid_i && last_beat) state_nxt = RESP;
      end
      RESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign axi_bid_o   = id_q;
  assign axi_bresp_o = err_q ? 2'b10 : 2'b00;
  assign mem_addr_o  = waddr_q[MEM_ADDR_W-1:0];
  assign mem_wdata_o = axi_wdata_i;
  assign mem_wstrb_o = axi_wstrb_i;

endmodule

// File: tb/tb_iob_cache_axi_write_responder.sv
module tb_iob_cache_axi_write_responder;

`ifdef IOB_CACHE_AXI_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [0:0]  awid = '0;
  logic [23:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = 2'b01;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  iob_cache_axi_write_responder dut (
    .clk_i(clk), .reset_i(reset_i),
    .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen),
    .axi_awsize_i(awsize), .axi_awburst_i(awburst), .axi_awvalid_i(awvalid),
    .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
    .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb)
  );

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
  } wexp_t;

  typedef struct {
    logic [0:0] id;
    logic [1:0] resp;
  } bexp_t;

  typedef struct {
    logic [0:0]  id;
    logic [23:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          wlast_idx;
    bit          gap;
    bit          oor;
    logic [9:0]  exp_a0;
    bit          exp_step;
    logic [1:0]  exp_resp;
  } vec_t;

  wexp_t wq[$];
  bexp_t bq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    checks++;
    if ((32'(awready) + 32'(wready) + 32'(bvalid)) > 1) begin
      errors++;
      $display("FAIL handshake_exclusive actual=aw%0b w%0b b%0b required=at most one",
               awready, wready, bvalid);
    end
    if (mem_en) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=addr %0h required=no write", mem_addr);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(e.a));
        chk("mem_wdata", 64'(mem_wdata), 64'(e.d));
        chk("mem_wstrb", 64'(mem_wstrb), 64'(e.s));
      end
    end
    if (bvalid && bready) begin
      if (bq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_b actual=id %0h resp %0h required=no response", bid, bresp);
      end else begin
        bexp_t b;
        b = bq.pop_front();
        chk("bid", 64'(bid), 64'(b.id));
        chk("bresp", 64'(bresp), 64'(b.resp));
      end
    end
  end

  task automatic do_aw(input logic [0:0] id, input logic [23:0] addr,
                       input logic [7:0] len, input logic [1:0] burst);
    int n;
    awid = id; awaddr = addr; awlen = len; awburst = burst;
    awsize = 3'($urandom_range(0, 7));
    awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_handshake", 64'(awready), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic do_beat(input bit gap, input bit last, input bit exp_en, input logic [9:0] exp_a);
    int n;
    wexp_t e;
    if (gap) begin @(posedge clk); #1; end
    wdata  = $urandom;
    wstrb  = 4'($urandom_range(1, 15));
    wlast  = last;
    wvalid = 1'b1;
    if (exp_en) begin
      e.a = exp_a; e.d = wdata; e.s = wstrb;
      wq.push_back(e);
    end
    n = 0;
    @(negedge clk);
    while (!wready && n < 50) begin @(negedge clk); n++; end
    chk("w_handshake", 64'(wready), 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk("b_handshake", 64'(bvalid), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    bexp_t be;
    logic [9:0] a;
    bit en;

    //         id    addr       len   burst  wlast gap oor a0     step resp
    vecs[0] = '{1'b1, 24'h10,   8'd0, 2'b01, 0,    0,  0,  10'd4,  1, 2'b00}; // single
    vecs[1] = '{1'b0, 24'h0,    8'd3, 2'b01, 3,    1,  0,  10'd0,  1, 2'b00}; // INCR, gapped
    vecs[2] = '{1'b0, 24'h8,    8'd2, 2'b00, 2,    0,  0,  10'd2,  0, 2'b00}; // FIXED
    vecs[3] = '{1'b1, 24'h0,    8'd3, 2'b01, 1,    0,  0,  10'd0,  1, 2'b10}; // early wlast
    vecs[4] = '{1'b0, 24'h20,   8'd1, 2'b10, 1,    1,  0,  10'd8,  1, 2'b10}; // reserved burst
    vecs[5] = '{1'b1, 24'h1000, 8'd0, 2'b01, 0,    0,  1,  10'd0,  1, 2'b00}; // above range
    vecs[6] = '{1'b0, 24'hFFC,  8'd1, 2'b01, 1,    0,  0,  10'd1023, 1, 2'b00}; // wrap
    vecs[7] = '{1'b1, 24'h43,   8'd7, 2'b01, 7,    1,  0,  10'd16, 1, 2'b00}; // unaligned, 8 beats

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;

    for (int v = 0; v < 8; v++) begin
      en = !(vecs[v].oor && RC);
      be.id = vecs[v].id;
      be.resp = en ? vecs[v].exp_resp : 2'b10;
      bq.push_back(be);
      do_aw(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst);
      a = vecs[v].exp_a0;
      for (int i = 0; i <= int'(vecs[v].len); i++) begin
        do_beat(vecs[v].gap && i > 0, i == vecs[v].wlast_idx, en, a);
        if (vecs[v].exp_step) a = a + 10'd1;
      end
      wait_b();
    end

    // B backpressure: response must hold for 5 stalled cycles.
    bready = 1'b0;
    be.id = 1'b1; be.resp = 2'b00;
    bq.push_back(be);
    do_aw(1'b1, 24'h30, 8'd1, 2'b01);
    do_beat(0, 0, 1, 10'd12);
    do_beat(0, 1, 1, 10'd13);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_bvalid", 64'(bvalid), 64'd1);
      chk("hold_bid", 64'(bid), 64'd1);
      chk("hold_bresp", 64'(bresp), 64'd0);
      chk("hold_awready", 64'(awready), 64'd0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;

    // Reset during the third beat slot: burst abandoned, no B.
    do_aw(1'b0, 24'h50, 8'd3, 2'b01);
    do_beat(0, 0, 1, 10'd20);
    do_beat(0, 0, 1, 10'd21);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_awready", 64'(awready), 64'd1);
    chk("mid_rst_wready", 64'(wready), 64'd0);
    chk("mid_rst_bvalid", 64'(bvalid), 64'd0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;

    // Recovery after reset: counter and error flag start clean.
    be.id = 1'b1; be.resp = 2'b00;
    bq.push_back(be);
    do_aw(1'b1, 24'h7C, 8'd0, 2'b01);
    do_beat(0, 1, 1, 10'd31);
    wait_b();

    repeat (3) @(negedge clk);
    chk("writes_drained", 64'(wq.size()), 64'd0);
    chk("resps_drained", 64'(bq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_cache_axi_write_responder.md
IOB_CACHE_AXI_WRITE_RESPONDER -- requirements
Module: iob_cache_axi_write_responder

Interface
REQ-001 Parameter AXI_ID_W, default 1: AXI ID width.
REQ-002 Parameter AXI_ADDR_W, default 24: AXI byte-address width.
REQ-003 Parameter AXI_DATA_W, default 32: AXI data width; power of two, at least 8.
REQ-004 Parameter AXI_LEN_W, default 8: burst-length field width.
REQ-005 Parameter MEM_ADDR_W, default 10: backing-memory word-address width.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all state on rising edge.
- reset_i  in  1  synchronous active-high reset.
REQ-007 Write-address channel ports SHALL be:
- axi_awid_i  in  AXI_ID_W
- axi_awaddr_i  in  AXI_ADDR_W
- axi_awlen_i  in  AXI_LEN_W
- axi_awsize_i  in  3
- axi_awburst_i  in  2
- axi_awvalid_i  in  1
- axi_awready_o  out  1
REQ-008 Write-data channel ports SHALL be:
- axi_wdata_i  in  AXI_DATA_W
- axi_wstrb_i  in  AXI_DATA_W/8
- axi_wlast_i  in  1
- axi_wvalid_i  in  1
- axi_wready_o  out  1
REQ-009 Write-response channel ports SHALL be:
- axi_bid_o  out  AXI_ID_W
- axi_bresp_o  out  2
- axi_bvalid_o  out  1
- axi_bready_i  in  1
REQ-010 Memory-side ports SHALL be:
- mem_en_o  out  1  write enable.
- mem_addr_o  out  MEM_ADDR_W  word address.
- mem_wdata_o  out  AXI_DATA_W  write data.
- mem_wstrb_o  out  AXI_DATA_W/8  byte enables.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, DATA and RESP, and SHALL handle one burst at a time.
REQ-012 In IDLE: axi_awready_o=1; on axi_awvalid_i, capture awid, awaddr word-aligned (low log2(AXI_DATA_W/8) bits zeroed), awlen and awburst; clear the beat counter and error flag; next state DATA.
REQ-013 In DATA: axi_wready_o=1; each beat is axi_wvalid_i high in DATA.
REQ-014 Per beat: mem_en_o=1 in the same cycle (combinational); mem_wdata_o=axi_wdata_i; mem_wstrb_o=axi_wstrb_i; mem_addr_o=current word address bits [MEM_ADDR_W+log2(AXI_DATA_W/8)-1 : log2(AXI_DATA_W/8)].
REQ-015 After each beat, in the following cycle:
- awburst=2'b01 (INCR): word address +1.
- awburst=2'b00 (FIXED): address unchanged.
- awburst=2'b10 or 2'b11: treated as INCR, error flag set.
REQ-016 The beat counter SHALL be AXI_LEN_W bits; the beat with counter==awlen ends the burst, next state RESP. Total beats = awlen+1; awlen=0 is a single beat.
REQ-017 Any beat where axi_wlast_i differs from (counter==awlen) SHALL set the error flag; burst length is always governed by awlen, never by wlast.
REQ-018 Memory word addresses SHALL wrap modulo 2^MEM_ADDR_W.
REQ-019 In RESP: axi_bvalid_o=1; axi_bid_o=captured awid; axi_bresp_o=2'b10 (SLVERR) if the error flag is set, else 2'b00. All three SHALL hold stable until axi_bready_i; on axi_bready_i, next state IDLE.
REQ-020 axi_awready_o, axi_wready_o and axi_bvalid_o SHALL be mutually exclusive; no combinational path from axi_bready_i to axi_awready_o.
REQ-021 axi_awsize_i SHALL be ignored; every beat is full AXI_DATA_W width, with byte masking via wstrb only.
REQ-022 Outside DATA, mem_en_o=0; mem_addr_o, mem_wdata_o and mem_wstrb_o are don't-care.

Reset
REQ-023 On reset_i high at a clock edge, state=IDLE, counter=0, error flag=0, and axi_bvalid_o, axi_wready_o and mem_en_o are 0; axi_awready_o is 1 from the next cycle.
REQ-024 Reset mid-burst or in RESP SHALL abandon the burst with no B response issued; memory writes already performed are not undone.

Configuration
REQ-025 Macro IOB_CACHE_AXI_RANGE_CHECK_EN: when defined, a beat whose word address has nonzero bits above the MEM_ADDR_W field SHALL have mem_en_o=0 and SHALL set the error flag (SLVERR).
REQ-026 Without IOB_CACHE_AXI_RANGE_CHECK_EN, the upper address bits SHALL be ignored and the write aliases into memory.

Verification
REQ-027 Single write: AW addr=0x10, len=0, id=1; W data=0xA5A5A5A5, strb=0xF, last=1 -> mem_en_o for one cycle at mem_addr=4; B resp=00, id=1.
REQ-028 INCR burst: addr=0x0, len=3, four beats, W valid gapped every other cycle -> mem_addr 0,1,2,3; exactly one B, resp=00.
REQ-029 FIXED burst: addr=0x8, burst=00, len=2 -> three writes all at mem_addr=2; resp=00.
REQ-030 wlast error: len=3 with wlast on beat 1 -> four writes still occur; resp=10.
REQ-031 Backpressure/reset: hold bready=0 for 5 cycles -> bvalid, bresp and bid stable, awready=0; a second run asserting reset in beat 2 -> no B issued, awready=1 after reset.
REQ-032 Range/wrap (MEM_ADDR_W=10): addr=0x1000, len=0 -> with IOB_CACHE_AXI_RANGE_CHECK_EN: mem_en_o=0, resp=10; without: write at mem_addr=0, resp=00; INCR from word 1023, len=1 -> second write at mem_addr=0.
